// File: rtl/uart_rx.sv
// uart_rx - UART receiver, the far end of the team's UART transmitter.
//
// Frame: start bit (0), WIDTH data bits LSB first, optional parity bit,
// one stop bit (1). The line idles high. RX_IN is synchronised by two flops,
// then oversampled at PRESCALE clocks per bit.
//
// Parameters:
//   WIDTH     data bits per frame
//   PRESCALE  CLK cycles per bit (even, >= 4)
//
// Ports:
//   CLK         system clock
//   RST         asynchronous active-low reset
//   RX_IN       serial line, asynchronous, idles 1
//   PAR_EN      1 = frame carries a parity bit (latched while idle)
//   PAR_TYPE    0 = even, 1 = odd (latched while idle)
//   P_DATA      received word, held until the next good frame
//   DATA_VALID  one-cycle pulse, P_DATA valid
//   PAR_ERR     one-cycle pulse, parity mismatch
//   STP_ERR     one-cycle pulse, stop bit sampled 0
//
// Build option:
//   UART_RX_MAJORITY_VOTE_EN  when defined, each bit is the 2-of-3 majority
//   of rx_s at edges PRESCALE/2-2 .. PRESCALE/2, decided at PRESCALE/2.
//   Otherwise a single sample is taken at edge PRESCALE/2-1.

module uart_rx #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_IN,
    input  logic             PAR_EN,
    input  logic             PAR_TYPE,
    output logic [WIDTH-1:0] P_DATA,
    output logic             DATA_VALID,
    output logic             PAR_ERR,
    output logic             STP_ERR
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int unsigned SMP_POS = PRESCALE / 2;
`else
    localparam int unsigned SMP_POS = PRESCALE / 2 - 1;
`endif
    localparam logic [CW-1:0] SMP_EDGE  = CW'(SMP_POS);
    localparam logic [CW-1:0] LAST_EDGE = CW'(PRESCALE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            rx_meta;
    logic            rx_s;
    logic [CW-1:0]   edge_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [WIDTH-1:0] shift;
    logic            par_en_q;
    logic            par_type_q;
    logic            par_bad;
    logic            smp;
    logic            at_smp;
    logic            at_wrap;
    logic            resolve;
    logic            dv_next;
    logic            perr_next;
    logic            stp_next;

    // Two-flop synchroniser, resets to the idle level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    assign at_smp  = (edge_cnt == SMP_EDGE);
    assign at_wrap = (edge_cnt == LAST_EDGE);

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] VOTE0_EDGE = CW'(SMP_POS - 2);
    localparam logic [CW-1:0] VOTE1_EDGE = CW'(SMP_POS - 1);
    logic vote0;
    logic vote1;

    // Captured in every state; IDLE holds edge_cnt at 0 so the first start
    // bit vote still lines up with the detection cycle when PRESCALE is 4.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vote0 <= 1'b1;
            vote1 <= 1'b1;
        end else begin
            if (edge_cnt == VOTE0_EDGE) vote0 <= rx_s;
            if (edge_cnt == VOTE1_EDGE) vote1 <= rx_s;
        end
    end

    assign smp = (vote0 & vote1) | (vote0 & rx_s) | (vote1 & rx_s);
`else
    assign smp = rx_s;
`endif

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (!rx_s) state_next = START;
            START: begin
                if (at_smp && smp) state_next = IDLE;
                else if (at_wrap)  state_next = DATA;
            end
            DATA:   if (at_wrap && bit_cnt == LAST_BIT)
                        state_next = par_en_q ? PARITY : STOP;
            PARITY: if (at_wrap) state_next = STOP;
            // Leaves at the sample point so a following start bit with no
            // idle gap is caught on time.
            STOP:   if (at_smp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode (registered below)
    always_comb begin
        resolve   = (state == STOP) && at_smp;
        dv_next   = resolve && smp && !par_bad;
        stp_next  = resolve && !smp;
        perr_next = resolve && par_bad;
    end

    // Datapath: counters, shift register, parity tracking.
    // The IDLE cycle that sees rx_s==0 is edge 0, so START begins at edge 1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_bad    <= 1'b0;
        end else begin
            if (state_next == IDLE)  edge_cnt <= '0;
            else if (state == IDLE)  edge_cnt <= CW'(1);
            else if (at_wrap)        edge_cnt <= '0;
            else                     edge_cnt <= edge_cnt + 1'b1;

            if (state != DATA)  bit_cnt <= '0;
            else if (at_wrap)   bit_cnt <= bit_cnt + 1'b1;

            if (state == DATA && at_smp) shift <= {smp, shift[WIDTH-1:1]};

            if (state == IDLE) begin
                par_en_q   <= PAR_EN;
                par_type_q <= PAR_TYPE;
            end

            if (state == START)
                par_bad <= 1'b0;
            else if (state == PARITY && at_smp)
                par_bad <= ((^shift) ^ par_type_q) != smp;
        end
    end

    // Registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= dv_next;
            PAR_ERR    <= perr_next;
            STP_ERR    <= stp_next;
            if (dv_next) P_DATA <= shift;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - self-checking bench for uart_rx (WIDTH=8, PRESCALE=8).
// Expected frame outcomes are queued as each frame is driven and compared
// whenever the receiver pulses one of its outputs.

module tb_uart_rx;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned PRESCALE = 8;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             RX_IN = 1'b1;
    logic             PAR_EN = 1'b0;
    logic             PAR_TYPE = 1'b0;
    logic [WIDTH-1:0] P_DATA;
    logic             DATA_VALID;
    logic             PAR_ERR;
    logic             STP_ERR;

    uart_rx #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYPE   (PAR_TYPE),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    // flags = {DATA_VALID, PAR_ERR, STP_ERR}
    typedef struct packed {
        logic [2:0] flags;
        logic [7:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned dv_times[$];
    logic [7:0]  last_good = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Any output pulse consumes one scoreboard entry; a pulse longer than one
    // cycle or a spurious pulse finds nothing queued and is reported.
    always @(negedge CLK) begin
        if (DATA_VALID || PAR_ERR || STP_ERR) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("flags", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'(mon_e.flags));
                check("p_data", 32'(P_DATA), 32'(mon_e.data));
                if (DATA_VALID) dv_times.push_back(cyc);
            end
        end
    end

    task automatic drive_bit(input logic b, input logic glitch);
        for (int k = 0; k < int'(PRESCALE); k++) begin
            RX_IN = (glitch && k == int'(PRESCALE / 2 - 1)) ? ~b : b;
            @(negedge CLK);
        end
    endtask

    // A zero stop bit is held only long enough to cover the sample window,
    // so the receiver's restart after the error turns into a false start.
    task automatic drive_stop_low();
        for (int k = 0; k < int'(PRESCALE); k++) begin
            RX_IN = (k < int'(PRESCALE / 2 + 2)) ? 1'b0 : 1'b1;
            @(negedge CLK);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                              input logic pflip, input logic stop, input int glitch);
        logic good;
        logic pbit;
        PAR_EN   = pen;
        PAR_TYPE = ptype;
        good = stop && !(pen && pflip);
        sb.push_back({good, pen && pflip, ~stop, good ? d : last_good});
        if (good) last_good = d;
        pbit = (^d) ^ ptype ^ pflip;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], glitch == i);
        if (pen) drive_bit(pbit, 1'b0);
        if (stop) drive_bit(1'b1, 1'b0);
        else      drive_stop_low();
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge CLK);
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_p_data"}, 32'(P_DATA), 32'd0);
        check({tag, "_dv"},     32'(DATA_VALID), 32'd0);
        check({tag, "_perr"},   32'(PAR_ERR), 32'd0);
        check({tag, "_serr"},   32'(STP_ERR), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0;
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        check_outputs_zero("reset");
        RST = 1'b1;
        idle(16);

        // Plain frame, no parity
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1); idle(16);
        // Even parity: correct, then wrong parity bit
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, -1); idle(16);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, -1); idle(16);
        // Odd parity: correct, then zero stop bit
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, -1); idle(16);
        send_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, -1); idle(16);
        // Parity and stop errors together
        send_frame(8'h99, 1'b1, 1'b0, 1'b1, 1'b0, -1); idle(16);
        drain();

        // Short low glitch is a false start; next frame still decodes
        PAR_EN = 1'b0;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        idle(24);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1); idle(16);
        drain();

        // Back-to-back frames with no idle between them
        dv_times.delete();
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(16);
        drain();
        if (dv_times.size() == 2)
            check("b2b_gap", 32'(dv_times[1] - dv_times[0]), 32'(10 * PRESCALE));
        else
            check("b2b_count", 32'(dv_times.size()), 32'd2);

        // Reset in the middle of the data bits of 0xFF
        PAR_EN = 1'b0;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        RST = 1'b0;
        RX_IN = 1'b1;
        #1;
        check_outputs_zero("midreset");
        repeat (4) @(negedge CLK);
        check_outputs_zero("holdreset");
        RST = 1'b1;
        last_good = 8'h00;
        idle(16);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1); idle(16);
        drain();

`ifdef UART_RX_MAJORITY_VOTE_EN
        // One-clock glitch at the centre of data bit 2 is outvoted
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 2); idle(16);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the far end of the team's UART transmitter. Frame format is the same as the TX side:
- start bit (0), WIDTH data bits LSB first, optional parity bit, one stop bit (1).
- Line idles high.

The block oversamples RX_IN at PRESCALE clocks per bit and reassembles P_DATA. It reports a one-cycle DATA_VALID pulse for a good frame, or an error pulse for a bad one. It sits between the pad and the consumer logic.

Parameters:
- WIDTH, 8, data bits per frame.
- PRESCALE, 8, CLK cycles per bit; even, >= 4.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset; this is the only clock and reset.
- RX_IN  in  1  serial line; asynchronous, idles 1.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYPE  in  1  0 = even, 1 = odd.
- P_DATA  out  WIDTH  received word; held until the next good frame.
- DATA_VALID  out  1  one-cycle pulse, P_DATA valid.
- PAR_ERR  out  1  one-cycle pulse, parity mismatch.
- STP_ERR  out  1  one-cycle pulse, stop bit sampled 0.

Behaviour:
- Reset (RST low, asynchronous): state IDLE, counters 0, P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, synchronizer flops=1.
- RX_IN passes through a 2-flop synchronizer (rx_s). All later references use rx_s.
- edge_cnt counts 0..PRESCALE-1 within a bit and wraps. bit_cnt counts 0..WIDTH-1.
- Sample point: edge_cnt == PRESCALE/2-1. The sampled value is "smp".
- States:
  - IDLE: on rx_s==0 go to START, edge_cnt=0. That cycle is edge 0. PAR_EN and PAR_TYPE are latched here; later changes are ignored until the next frame.
  - START: at the sample point, smp==1 is a false start: go to IDLE, no outputs. At edge_cnt==PRESCALE-1 go to DATA.
  - DATA: at each sample point, shift smp into the shift register MSB side, so the first bit lands in bit 0 after WIDTH shifts. At edge_cnt wrap with bit_cnt==WIDTH-1, go to PARITY if the latched PAR_EN is 1, else STOP.
  - PARITY: at the sample point compute the expected parity = (^shift) ^ PAR_TYPE latched, and record a mismatch flag. At wrap go to STOP.
  - STOP: at the sample point resolve the frame and go straight to IDLE, without waiting for the bit end. This allows back-to-back frames with zero idle.
- Frame resolution, on the clock after the stop sample point (registered outputs):
  - stop=1 and no parity mismatch: DATA_VALID=1 and P_DATA updated in the same cycle.
  - stop=0: STP_ERR=1.
  - parity mismatch: PAR_ERR=1.
  - Both errors can pulse together.
  - Whenever any error pulses, DATA_VALID=0 and P_DATA is unchanged.
- All pulses are exactly one cycle.
- Latency: DATA_VALID rises 2 (synchronizer) + 1 cycles after the stop-bit sample point in RX_IN time.
- Break (line held 0): gives STP_ERR, then IDLE sees rx_s==0 and restarts, repeating every frame time until the line returns to 1.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: smp is the 2-of-3 majority of rx_s at edge_cnt PRESCALE/2-2, PRESCALE/2-1 and PRESCALE/2, with the decision taken at PRESCALE/2. The sample point and all resolution timing shift one cycle later, so DATA_VALID latency becomes 2+2 cycles.
- Not defined: single sample at PRESCALE/2-1, as described above.
- Frame format and error rules are identical in both builds.

Test Plan:
- PRESCALE=8, PAR_EN=0, send 0xA5 at 8 clk/bit -> single DATA_VALID pulse, P_DATA=0xA5, PAR_ERR=STP_ERR=0.
- PAR_EN=1, PAR_TYPE=0, send 0x03 with parity bit 0 -> DATA_VALID, P_DATA=0x03. Resend with parity bit 1 -> PAR_ERR pulse, no DATA_VALID, P_DATA stays 0x03.
- PAR_EN=1, PAR_TYPE=1, send 0x07 with parity 0 -> DATA_VALID, P_DATA=0x07. Then send 0x55 with stop bit 0 -> STP_ERR pulse only.
- RX_IN low for 2 clocks, then high -> no outputs, FSM back in IDLE. A following 0x3C frame is received correctly.
- Back-to-back 0x11 then 0xEE with no idle bit -> two DATA_VALID pulses, exactly 10 bit-times apart (80 clk), with correct data.
- Assert RST mid-DATA of 0xFF, release, then send 0x5A -> outputs 0 during reset, first pulse is DATA_VALID with 0x5A. With UART_RX_MAJORITY_VOTE_EN, a 1-clock glitch at a sample point is ignored.
